// File: rtl/vending_machine_param.sv
// Parametrised coin-operated vending controller: accumulates nickel/dime/quarter credit,
// pulses dispense at PRICE and returns change or refunds over a valid/ready handshake.
module vending_machine_param #(
    parameter int CREDIT_W    = 8,
    parameter int PRICE       = 35,
    parameter int NICKEL_VAL  = 5,
    parameter int DIME_VAL    = 10,
    parameter int QUARTER_VAL = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                change_ready,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject
);

    // state   | meaning
    // IDLE    | no credit held
    // COLLECT | 0 < credit < PRICE, accepting coins or cancel
    // VEND    | single cycle, dispense asserted
    // CHANGE  | change/refund offered, waiting for hopper handshake
    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        COLLECT = 3'b001,
        VEND    = 3'b010,
        CHANGE  = 3'b100
    } state_t;

    localparam logic [CREDIT_W:0]   NICKEL_X  = (CREDIT_W+1)'(NICKEL_VAL);
    localparam logic [CREDIT_W:0]   DIME_X    = (CREDIT_W+1)'(DIME_VAL);
    localparam logic [CREDIT_W:0]   QUARTER_X = (CREDIT_W+1)'(QUARTER_VAL);
    localparam logic [CREDIT_W:0]   PRICE_X   = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_d, amt_d;
    logic                  valid_d, disp_d, rej_d;
    logic [1:0]            coin_cnt;
    logic                  one_coin, multi_coin, any_coin;
    logic [CREDIT_W:0]     coin_val;
    logic [CREDIT_W:0]     sum;
    logic [CREDIT_W-1:0]   excess;
    logic                  accept_coin;

    assign coin_cnt   = 2'(nickel) + 2'(dime) + 2'(quarter);
    assign one_coin   = (coin_cnt == 2'd1);
    assign multi_coin = (coin_cnt > 2'd1);
    assign any_coin   = (coin_cnt != 2'd0);

    always_comb begin
        coin_val = '0;
        if (nickel)       coin_val = NICKEL_X;
        else if (dime)    coin_val = DIME_X;
        else if (quarter) coin_val = QUARTER_X;
    end

    // One extra bit so an overflow would be visible rather than silently wrapping.
    assign sum    = {1'b0, credit} + coin_val;
    assign excess = credit - PRICE_C;

    always_comb begin
        state_d     = state_q;
        credit_d    = credit;
        amt_d       = change_amt;
        valid_d     = change_valid;
        disp_d      = 1'b0;
        rej_d       = 1'b0;
        accept_coin = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && state_q == COLLECT) begin
                    // Full refund; a coin arriving alongside the cancel is diverted.
                    state_d = CHANGE;
                    amt_d   = credit;
                    valid_d = 1'b1;
                    rej_d   = any_coin;
                end else if (multi_coin) begin
                    rej_d = 1'b1;
                end else if (one_coin) begin
                    accept_coin = 1'b1;
                    credit_d    = sum[CREDIT_W-1:0];
                    if (sum >= PRICE_X) begin
                        state_d = VEND;
                        disp_d  = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            VEND: begin
                rej_d = any_coin;
                if (excess == '0) begin
                    state_d  = IDLE;
                    credit_d = '0;
                end else begin
                    state_d = CHANGE;
                    amt_d   = excess;
                    valid_d = 1'b1;
                end
            end
            CHANGE: begin
                rej_d = any_coin;
                if (change_ready) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    amt_d    = '0;
                    credit_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                amt_d    = '0;
                valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            credit       <= '0;
            change_amt   <= '0;
            change_valid <= 1'b0;
            dispense     <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            change_amt   <= amt_d;
            change_valid <= valid_d;
            dispense     <= disp_d;
            coin_reject  <= rej_d;
        end
    end

    a_no_credit_overflow : assert property (
        @(posedge clk) disable iff (rst) accept_coin |-> !sum[CREDIT_W]
    );

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: a transaction-level model predicts per-cycle
// status and output events; a negedge monitor compares whatever the DUT presents.
module tb_vending_machine_param;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic nickel, dime, quarter, cancel, change_ready;

    logic          dispense0, change_valid0, coin_reject0;
    logic [CW-1:0] change_amt0, credit0;
    logic          dispense1, change_valid1, coin_reject1;
    logic [CW-1:0] change_amt1, credit1;

    vending_machine_param #(.CREDIT_W(CW), .PRICE(35)) dut0 (
        .clk(clk), .rst(rst), .nickel(nickel), .dime(dime), .quarter(quarter),
        .cancel(cancel), .change_ready(change_ready), .dispense(dispense0),
        .change_valid(change_valid0), .change_amt(change_amt0), .credit(credit0),
        .coin_reject(coin_reject0)
    );

    vending_machine_param #(.CREDIT_W(CW), .PRICE(100)) dut1 (
        .clk(clk), .rst(rst), .nickel(nickel), .dime(dime), .quarter(quarter),
        .cancel(cancel), .change_ready(change_ready), .dispense(dispense1),
        .change_valid(change_valid1), .change_amt(change_amt1), .credit(credit1),
        .coin_reject(coin_reject1)
    );

    always #5 clk = ~clk;

    bit            sel = 1'b0;
    logic          d_disp, d_cv, d_rej;
    logic [CW-1:0] d_amt, d_credit;
    assign d_disp   = sel ? dispense1     : dispense0;
    assign d_cv     = sel ? change_valid1 : change_valid0;
    assign d_rej    = sel ? coin_reject1  : coin_reject0;
    assign d_amt    = sel ? change_amt1   : change_amt0;
    assign d_credit = sel ? credit1       : credit0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int credit;
        int cv;
        int amt;
    } status_t;

    status_t st_q[$];
    int      disp_q[$];
    int      rej_q[$];
    int      chg_q[$];
    status_t mon_s;

    // Reference model: money held, change owed, and whether a vend is in progress.
    int m_credit, m_owed, m_price;
    bit m_vend, m_chg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (st_q.size() > 0) begin
                mon_s = st_q.pop_front();
                check("credit", d_credit, mon_s.credit);
                check("change_valid", d_cv, mon_s.cv);
                check("change_amt", d_amt, mon_s.amt);
            end
            if (d_disp) begin
                if (disp_q.size() == 0) check("dispense_unexpected", d_disp, 0);
                else check("dispense_cycle", cyc, disp_q.pop_front());
            end
            if (disp_q.size() > 0 && disp_q[0] <= cyc) begin
                check("dispense_missing", d_disp, 1);
                void'(disp_q.pop_front());
            end
            if (d_rej) begin
                if (rej_q.size() == 0) check("reject_unexpected", d_rej, 0);
                else check("reject_cycle", cyc, rej_q.pop_front());
            end
            if (rej_q.size() > 0 && rej_q[0] <= cyc) begin
                check("reject_missing", d_rej, 1);
                void'(rej_q.pop_front());
            end
            if (d_cv && change_ready) begin
                if (chg_q.size() == 0) check("handshake_unexpected", d_cv, 0);
                else check("handshake_amt", d_amt, chg_q.pop_front());
            end
        end
    end

    task automatic model_step(input bit n, input bit d, input bit q, input bit c, input bit r);
        int coins;
        int val;
        coins = int'(n) + int'(d) + int'(q);
        val   = n ? 5 : (d ? 10 : 25);
        if (m_vend) begin
            m_vend = 1'b0;
            if (coins > 0) rej_q.push_back(cyc + 1);
            if (m_credit > m_price) begin
                m_chg  = 1'b1;
                m_owed = m_credit - m_price;
            end else begin
                m_credit = 0;
            end
        end else if (m_chg) begin
            if (coins > 0) rej_q.push_back(cyc + 1);
            if (r) begin
                chg_q.push_back(m_owed);
                m_chg    = 1'b0;
                m_owed   = 0;
                m_credit = 0;
            end
        end else if (c && m_credit > 0) begin
            m_chg  = 1'b1;
            m_owed = m_credit;
            if (coins > 0) rej_q.push_back(cyc + 1);
        end else if (coins > 1) begin
            rej_q.push_back(cyc + 1);
        end else if (coins == 1) begin
            m_credit += val;
            if (m_credit >= m_price) begin
                m_vend = 1'b1;
                disp_q.push_back(cyc + 1);
            end
        end
    endtask

    // One clock cycle of stimulus; the status pushed is what the DUT should show this cycle.
    task automatic drive(input bit n, input bit d, input bit q, input bit c, input bit r);
        @(posedge clk);
        #1;
        nickel = n; dime = d; quarter = q; cancel = c; change_ready = r;
        st_q.push_back('{m_credit, int'(m_chg), m_chg ? m_owed : 0});
        model_step(n, d, q, c, r);
    endtask

    task automatic idle(input int cycles, input bit r);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic rand_cycle();
        int rv;
        bit n, d, q, c, r;
        n = 1'b0; d = 1'b0; q = 1'b0; c = 1'b0;
        rv = int'($urandom_range(0, 99));
        r  = ($urandom_range(0, 3) != 0);
        if (rv < 50) begin
            case ($urandom_range(0, 2))
                0:       n = 1'b1;
                1:       d = 1'b1;
                default: q = 1'b1;
            endcase
        end else if (rv < 58) begin
            n = 1'($urandom_range(0, 1));
            d = 1'b1;
            q = 1'($urandom_range(0, 1));
        end else if (rv < 66) begin
            c = 1'b1;
            if (rv < 62) n = 1'b1;
        end
        drive(n, d, q, c, r);
    endtask

    task automatic drain_check();
        idle(4, 1'b1);
        @(negedge clk);
        #1;
        check("events_drained", disp_q.size() + rej_q.size() + chg_q.size(), 0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0; change_ready = 1'b0;
        st_q.delete(); disp_q.delete(); rej_q.delete(); chg_q.delete();
        m_credit = 0; m_owed = 0; m_vend = 1'b0; m_chg = 1'b0;
        m_price  = sel ? 100 : 35;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        do_reset();

        // Exact price, no change.
        drive(0, 0, 1, 0, 0); drive(0, 1, 0, 0, 0); idle(3, 0);
        // Overpay, change held while hopper is busy.
        drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0); idle(6, 0); idle(1, 1); idle(2, 0);
        // Refund, then cancel in IDLE does nothing.
        drive(1, 0, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 0, 0, 1, 0); idle(2, 0);
        idle(1, 1); drive(0, 0, 0, 1, 1); idle(3, 1);
        // Rejects: two coins, coin in VEND, coin in CHANGE, coin with cancel.
        drive(0, 1, 1, 0, 0); idle(1, 0);
        drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0); drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0); idle(1, 1); idle(1, 0);
        drive(1, 0, 0, 0, 0); drive(1, 0, 0, 1, 0); idle(1, 0); idle(1, 1); idle(2, 0);

        for (int i = 0; i < 600; i++) rand_cycle();
        drain_check();

        // Reset asserted while change is being offered.
        drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0); idle(2, 0);
        #2;
        mon_en = 1'b0;
        check("cv_before_reset", d_cv, 1);
        rst = 1'b1;
        #1;
        check("rst_dispense", d_disp, 0);
        check("rst_change_valid", d_cv, 0);
        check("rst_change_amt", d_amt, 0);
        check("rst_credit", d_credit, 0);
        check("rst_coin_reject", d_rej, 0);
        do_reset();
        idle(2, 1);
        drive(1, 0, 0, 0, 0); idle(2, 0);
        drain_check();

        // Price 100 instance.
        mon_en = 1'b0;
        sel = 1'b1;
        do_reset();
        repeat (4) drive(0, 0, 1, 0, 0);
        idle(2, 0);
        repeat (3) drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0); idle(1, 0);
        drive(0, 0, 1, 0, 0); idle(3, 0); idle(1, 1); idle(1, 0);
        for (int i = 0; i < 400; i++) rand_cycle();
        drain_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
